// File: rtl/rotate_stepper_pkg.sv
// Shared constants for the rotate_stepper sequencing stage.
package rotate_stepper_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/barrel_shifter.sv
// 4-bit rotate-right barrel shifter: y = w rotated right by s.
module barrel_shifter (
  input  logic [3:0] w,
  input  logic [1:0] s,
  output logic [3:0] y
);

  always_comb begin
    y = w;
    case (s)
      2'd0: y = w;
      2'd1: y = {w[0],   w[3:1]};
      2'd2: y = {w[1:0], w[3:2]};
      2'd3: y = {w[2:0], w[3]};
      default: y = w;
    endcase
  end

endmodule

// File: rtl/rotate_stepper.sv
// Loads a word and streams count successive rotate-right results over
// valid/ready, then pulses done for one cycle.
module rotate_stepper
  import rotate_stepper_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        step,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dout,
  output logic              done
);

  state_t              r_state;
  state_t              w_state_next;
  logic [DATA_W-1:0]   r_dout;
  logic                r_valid;
  logic                r_done;
  logic [1:0]          r_step;
  logic [CNT_W-1:0]    r_rem;

  logic                w_run;
  logic                w_hs;
  logic                w_last;
  logic [DATA_W-1:0]   w_sh_w;
  logic [1:0]          w_sh_s;
  logic [DATA_W-1:0]   w_sh_y;

  assign w_run  = (r_state == ST_RUN);
  assign w_hs   = w_run && r_valid && out_ready;
  assign w_last = (r_rem == CNT_W'(1));

  // In IDLE the shifter sees the incoming word; in RUN it re-rotates dout.
  assign w_sh_w = w_run ? r_dout : din;
  assign w_sh_s = w_run ? r_step : step;

  barrel_shifter u_shifter (
    .w (w_sh_w),
    .s (w_sh_s),
    .y (w_sh_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start && (count != '0)) w_state_next = ST_RUN;
      ST_RUN:  if (w_hs && w_last)         w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_step  <= '0;
      r_rem   <= '0;
    end else begin
      r_done <= 1'b0;
      if (!w_run) begin
        if (start) begin
          if (count != '0) begin
            r_step  <= step;
            r_rem   <= count;
            r_dout  <= w_sh_y;
            r_valid <= 1'b1;
          end else begin
            r_done <= 1'b1;
          end
        end
      end else if (w_hs) begin
        r_rem <= r_rem - CNT_W'(1);
        // Last beat accepted: dout keeps its value, valid drops as done rises.
        if (w_last) begin
          r_valid <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_dout <= w_sh_y;
        end
      end
    end
  end

  assign busy      = w_run;
  assign out_valid = r_valid;
  assign dout      = r_dout;
  assign done      = r_done;

endmodule
